// File: rtl/booth_mult_seq_if.sv
// rtl/booth_mult_seq_if.sv - request/result bundle for the sequential Booth multiplier
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             overflow;

  modport master (
    output start, abort, multiplicand, multiplier,
    input  busy, done, result_lo, result_hi, overflow
  );

  modport slave (
    input  start, abort, multiplicand, multiplier,
    output busy, done, result_lo, result_hi, overflow
  );
endinterface

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - radix-4 Booth signed multiplier, one add/shift step per clock
// Optional macro BOOTH_MULT_ZERO_BYPASS_EN: zero operand skips straight to DONE.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  booth_mult_seq_if.slave  bus
);

  localparam int EW = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               extra_q, extra_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [2:0]         triple;
  logic [EW-1:0]      hi_ext, a_ext, a2_ext, addend, sum;
  logic [2*WIDTH-1:0] p_step;
  logic               load_zero;

  // Two guard bits on the upper half keep +/-2A from wrapping.
  assign triple = {p_q[1], p_q[0], extra_q};
  assign hi_ext = {{2{p_q[2*WIDTH-1]}}, p_q[2*WIDTH-1:WIDTH]};
  assign a_ext  = {{2{a_q[WIDTH-1]}}, a_q};
  assign a2_ext = {a_q[WIDTH-1], a_q, 1'b0};

  always_comb begin
    addend = '0;
    case (triple)
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a2_ext;
      3'b100:         addend = -a2_ext;
      3'b101, 3'b110: addend = -a_ext;
      default:        addend = '0;
    endcase
  end

  assign sum    = hi_ext + addend;
  assign p_step = {sum, p_q[WIDTH-1:2]};

`ifdef BOOTH_MULT_ZERO_BYPASS_EN
  assign load_zero = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
  assign load_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    extra_d = extra_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.multiplicand;
          extra_d = 1'b0;
          cnt_d   = '0;
          if (load_zero) begin
            p_d     = '0;
            state_d = DONE;
          end else begin
            p_d     = {{WIDTH{1'b0}}, bus.multiplier};
            state_d = RUN;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          p_d     = p_step;
          extra_d = p_q[1];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = (p_d[2*WIDTH-1:WIDTH] != {WIDTH{p_d[WIDTH-1]}});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      p_q     <= '0;
      extra_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      extra_q <= extra_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.result_lo = p_q[WIDTH-1:0];
  assign bus.result_hi = p_q[2*WIDTH-1:WIDTH];
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - scoreboard bench for booth_mult_seq with directed vectors
module tb_booth_mult_seq;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    int          done_cyc;
    int          busy_n;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  int   busy_cnt;
  exp_t sb[$];

  booth_mult_seq_if #(.WIDTH(32)) bus ();

  booth_mult_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial busy_cnt = 0;
  always @(negedge clock) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", {bus.result_hi, bus.result_lo}, {e.hi, e.lo});
        chk("overflow", 64'(bus.overflow), 64'(e.ovf));
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("busy_cycles", 64'(busy_cnt), 64'(e.busy_n));
      end
      busy_cnt = 0;
    end else if (bus.busy) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  // Drives start for one cycle from the current negedge; push=0 means no result expected.
  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] hi, input logic [31:0] lo, input logic ovf,
                    input bit push);
    exp_t e;
    bit   byp;
    byp = 1'b0;
`ifdef BOOTH_MULT_ZERO_BYPASS_EN
    byp = (a == 32'd0) || (b == 32'd0);
`endif
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    e.hi       = hi;
    e.lo       = lo;
    e.ovf      = ovf;
    e.done_cyc = byp ? cyc + 1 : cyc + 17;
    e.busy_n   = byp ? 0 : 16;
    if (push) sb.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      if (bus.done) return;
      @(negedge clock);
    end
    chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_lo", 64'(bus.result_lo), 64'd0);
    chk("rst_hi", 64'(bus.result_hi), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    op(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
    wait_done("mul_7_m3");
    @(negedge clock);
    op(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1, 1'b1);
    wait_done("mul_min_min");
    @(negedge clock);
    op(32'h7FFF_FFFF, 32'd2, 32'h0000_0000, 32'hFFFF_FFFE, 1'b1, 1'b1);
    wait_done("mul_max_2");
    @(negedge clock);
    op(32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1);
    wait_done("mul_min_m1");
    @(negedge clock);
    op(32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b1, 1'b1);
    wait_done("mul_pattern");

    // Start pulsed mid-RUN must be ignored; the second request lands in the DONE cycle.
    @(negedge clock);
    op(32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    op(32'd99, 32'd99, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_done("ignored_start");
    op(32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1'b1);
    wait_done("back_to_back");

    // Abort mid-RUN: no done, idle on the next cycle.
    @(negedge clock);
    op(32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (7) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b1);
    wait_done("after_abort");

    // Asynchronous reset mid-RUN clears every output immediately.
    @(negedge clock);
    op(32'd11, 32'd13, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_result", {bus.result_hi, bus.result_lo}, 64'd0);
    chk("arst_ovf", 64'(bus.overflow), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    op(32'hFFFF_FFFB, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0, 1'b1);
    wait_done("after_reset");

    @(negedge clock);
    op(32'd0, 32'd12345, 32'd0, 32'd0, 1'b0, 1'b1);
    wait_done("zero_operand");

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
